dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  Load/store sequencer between the single-cycle ARM datapath and the word-wide dmem
//  (combinational read, write on posedge clk). Adds byte stores via read-modify-write and
//  zero-extended byte loads over the word-only dmem.
//  Holds the core with busy_o until done_o pulses.
// PARAMETERS
//  DW  32  data width; fixed at 32; byte lanes are DW/8
//  AW  32  address width; byte address; dmem is word-indexed by addr[AW-1:2]
// PORTS
//  clk       in   1   clock, rising edge
//  reset_n   in   1   synchronous reset, active-low
//  req_i     in   1   access request, sampled in IDLE only
//  we_i      in   1   1 = store, 0 = load
//  byte_i    in   1   1 = byte access (LDRB/STRB), 0 = word
//  addr_i    in   AW  byte address
//  wdata_i   in   DW  store data; byte store uses wdata_i[7:0]
//  rdata_o   out  DW  load result, valid when done_o=1, held until next load completes
//  busy_o    out  1   1 whenever state != IDLE
//  done_o    out  1   one-cycle completion pulse
//  dm_we     out  1   dmem write enable
//  dm_a      out  AW  dmem address, always {addr[AW-1:2],2'b00}
//  dm_wd     out  DW  dmem write data
//  dm_rd     in   DW  dmem read data (combinational from dm_a)
//  fault_o   out  1   misalignment fault pulse; present only with DMEM_MISALIGN_TRAP_EN
// BEHAVIOUR
//  - FSM states: IDLE, RD, WR, DONE.
//  - IDLE: dm_a = aligned addr_i. On req_i=1, latch addr, we, byte, wdata. Next state:
//    load -> RD; word store -> WR; byte store -> RD.
//  - RD: dm_a = aligned latched addr; dm_rd is captured into word buffer at the edge.
//    Load -> DONE; byte store -> WR.
//  - WR: dm_we=1. dm_wd = wdata (word) or the buffer with lane addr[1:0] replaced by
//    wdata[7:0] (little-endian: lane0=[7:0] .. lane3=[31:24]). Next state -> DONE.
//  - DONE: done_o=1. On a load, rdata_o is registered at the RD->DONE edge: the full
//    word, or {24'b0, selected lane}. Next state -> IDLE.
//  - Latency from req_i edge to done_o: word load 2, word store 2, byte load 2,
//    byte store 3 cycles.
//  - req_i while busy_o=1 is ignored, with no queuing.
//    Back-to-back requests are accepted in the cycle after DONE.
//  - Word access with addr[1:0]!=0: the low bits are ignored (word-aligned), unless
//    DMEM_MISALIGN_TRAP_EN is defined.
//  - dm_we = (state==WR) & reset_n, so no dmem write occurs at an edge where reset
//    is asserted.
//  - Reset values: state IDLE, rdata_o 0, done_o 0, busy_o 0, dm_we 0, buffer 0,
//    fault_o 0.
//  - Reset mid-operation (RD or WR): access abandoned, memory unchanged, no done_o.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: a word request with addr_i[1:0]!=0 goes IDLE->DONE
//    with fault_o=1 and done_o=1 in DONE. dm_we stays 0, rdata_o is unchanged.
//    Byte accesses never fault.
//  Not defined: fault_o port absent; misaligned word accesses are silently aligned.
// TESTING
//  1 reset_n=0 for 2 cycles -> busy_o=0, done_o=0, dm_we=0, rdata_o=0.
//  2 word store 66 @100, then word load @100 -> dm_we=1 for exactly 1 cycle with
//    dm_a=100, dm_wd=66. Load: done_o 2 cycles after req, rdata_o=66.
//  3 word store 0x11223344 @0; byte store 0xAB @1 -> RD, then WR with dm_wd=0x1122AB44,
//    done_o at cycle 3. Byte load @3 -> rdata_o=0x00000011.
//  4 byte store 0x55 @4; re-assert req_i (load @8) during RD -> ignored.
//    Only one done_o; word @8 unchanged.
//  5 byte store @1 with reset_n=0 in RD or WR cycle -> no write;
//    word @0 still 0x1122AB44; FSM in IDLE.
//  6 word load @2: with macro -> fault_o=1, done_o=1, dm_we=0, rdata_o unchanged.
//    Without macro -> rdata_o = word @0.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store sequencer adding byte read-modify-write stores and zero-extended byte loads over a word-wide dmem.
// Optional misaligned word-access trap (and fault_o port) enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit #(
   parameter int DW = 32,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_i,
   input  logic          we_i,
   input  logic          byte_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          dm_we,
   output logic [AW-1:0] dm_a,
   output logic [DW-1:0] dm_wd,
   input  logic [DW-1:0] dm_rd
`ifdef DMEM_MISALIGN_TRAP_EN
   ,
   output logic          fault_o
`endif
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   state_t        r_state, w_next;
   logic [AW-1:0] r_addr;
   logic          r_we, r_byte;
   logic [DW-1:0] r_wdata, r_buf, w_merge;
   logic [7:0]    w_lane;
   logic          w_trap;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic          r_fault;
   assign w_trap = ~byte_i & (addr_i[1:0] != 2'b00);
`else
   assign w_trap = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = !req_i ? IDLE : w_trap ? DONE : (we_i & ~byte_i) ? WR : RD;
         RD:      w_next = r_we ? WR : DONE;
         WR:      w_next = DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_byte  <= 1'b0;
         r_wdata <= '0;
         r_buf   <= '0;
         rdata_o <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
         r_fault <= 1'b0;
`endif
      end else begin
         if (r_state == IDLE && req_i) begin
            r_addr  <= addr_i;
            r_we    <= we_i;
            r_byte  <= byte_i;
            r_wdata <= wdata_i;
`ifdef DMEM_MISALIGN_TRAP_EN
            r_fault <= w_trap;
`endif
         end
         if (r_state == RD) r_buf <= dm_rd;
         if (r_state == RD && !r_we) rdata_o <= r_byte ? {{(DW-8){1'b0}}, w_lane} : dm_rd;
      end
   end
   // Little-endian lane select: lane n occupies bits [8n+7:8n]
   always_comb begin
      w_lane  = dm_rd[{r_addr[1:0], 3'b000} +: 8];
      w_merge = r_buf;
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
   end
   always_comb begin
      busy_o = r_state != IDLE;
      done_o = r_state == DONE;
      dm_we  = (r_state == WR) & reset_n;
      dm_a   = {(r_state == IDLE) ? addr_i[AW-1:2] : r_addr[AW-1:2], 2'b00};
      dm_wd  = r_byte ? w_merge : r_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
      fault_o = (r_state == DONE) & r_fault;
`endif
   end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: randomized self-checking bench against a word-array reference memory model.
// Honors DMEM_MISALIGN_TRAP_EN to expect trapping of misaligned word accesses.
module tb_dmem_access_unit;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_i, we_i, byte_i;
   logic [31:0] addr_i, wdata_i, rdata_o, dm_a, dm_wd, dm_rd;
   logic        busy_o, done_o, dm_we;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic        fault_o;
`endif
   logic [31:0] mem [256] = '{default: 32'h0};
   logic [31:0] ref_mem [256] = '{default: 32'h0};
   logic [31:0] exp_rdata;
   int          w_cnt = 0;
   logic [31:0] w_a, w_d;
   int          n_cmp = 0, n_err = 0;
   dmem_access_unit dut (
      .clk(clk), .reset_n(reset_n), .req_i(req_i), .we_i(we_i), .byte_i(byte_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .busy_o(busy_o),
      .done_o(done_o), .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd), .dm_rd(dm_rd)
`ifdef DMEM_MISALIGN_TRAP_EN
      , .fault_o(fault_o)
`endif
   );
   always #5 clk = ~clk;
   assign dm_rd = mem[dm_a[9:2]];
   always @(posedge clk) begin
      if (dm_we) begin
         mem[dm_a[9:2]] <= dm_wd;
         w_cnt <= w_cnt + 1;
         w_a <= dm_a;
         w_d <= dm_wd;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic access(input bit we, input bit byt, input logic [31:0] addr, input logic [31:0] wdata, input bit poke);
      int cyc, lat, wc0, idx, l;
      bit trap;
      @(negedge clk);
      check("idle_busy", busy_o, 0);
      check("idle_done", done_o, 0);
      wc0 = w_cnt;
      trap = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
      trap = !byt && addr[1:0] != 2'b00;
`endif
      lat = trap ? 1 : (we && byt) ? 3 : 2;
      req_i = 1; we_i = we; byte_i = byt; addr_i = addr; wdata_i = wdata;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (poke) begin
            req_i = 1; we_i = 0; byte_i = 1; addr_i = 32'd8;
         end else req_i = 0;
         if (!done_o) check("busy", busy_o, 1);
      end while (!done_o && cyc < 8);
      req_i = 0;
      check("latency", cyc, lat);
      idx = int'(addr[9:2]);
      l = int'(addr[1:0]);
      if (!trap) begin
         if (we) begin
            if (byt) ref_mem[idx][8*l +: 8] = wdata[7:0];
            else ref_mem[idx] = wdata;
         end else exp_rdata = byt ? {24'h0, ref_mem[idx][8*l +: 8]} : ref_mem[idx];
      end
      check("writes", w_cnt - wc0, (we && !trap) ? 1 : 0);
      if (we && !trap) begin
         check("wr_addr", w_a, {addr[31:2], 2'b00});
         check("wr_data", w_d, ref_mem[idx]);
      end
      check("rdata", rdata_o, exp_rdata);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("fault", fault_o, trap);
`endif
   endtask
   task automatic rst_mid(input int at);
      int wc0;
      @(negedge clk);
      wc0 = w_cnt;
      req_i = 1; we_i = 1; byte_i = 1; addr_i = 32'd1; wdata_i = 32'h77;
      @(negedge clk);
      req_i = 0;
      if (at == 2) @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      exp_rdata = 0;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_rdata", rdata_o, 0);
      check("rst_writes", w_cnt - wc0, 0);
   endtask
   initial begin
      reset_n = 0; req_i = 0; we_i = 0; byte_i = 0; addr_i = 0; wdata_i = 0;
      exp_rdata = 0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy_o, 0);
      check("reset_done", done_o, 0);
      check("reset_we", dm_we, 0);
      check("reset_rdata", rdata_o, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("reset_fault", fault_o, 0);
`endif
      reset_n = 1;
      access(1, 0, 32'd100, 32'd66, 0);
      access(0, 0, 32'd100, 32'd0, 0);
      access(1, 0, 32'd0, 32'h11223344, 0);
      access(1, 1, 32'd1, 32'hAB, 0);
      access(0, 1, 32'd3, 32'd0, 0);
      access(1, 1, 32'd4, 32'h55, 1);
      rst_mid(1);
      rst_mid(2);
      check("mem0_kept", mem[0], 32'h1122AB44);
      access(0, 0, 32'd2, 32'd0, 0);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) @(negedge clk);
         access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom, 0);
      end
      for (int i = 0; i < 64; i++) check("mem_sweep", mem[i], ref_mem[i]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
